sysclk_timer: RTL
=================

Name: sysclk_timer

Overview:
- Parametrised successor to the free-running system-clock counter: a programmable timer peripheral on the CPU's memory-mapped peripheral bus.
- Provides an up-counter with:
  - a programmable reload value
  - a clock prescaler
  - auto-reload or one-shot mode
  - a sticky overflow status bit driving a maskable interrupt line
- The halt input freezes counting, for example while the CPU services an interrupt.

Parameters:
- WIDTH, 32, counter/reload/data width in bits (min 8).
- PRESCALE_W, 8, prescaler register width; tick period = PRESCALE+1 sysclk cycles.

Ports:
- sysclk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- halt  in  1  1 = freeze prescaler and counter; bus writes still accepted.
- wr_en  in  1  register write strobe, single cycle.
- addr  in  2  register select: 0 RELOAD, 1 COUNT, 2 CTRL, 3 PRESCALE.
- wr_data  in  WIDTH  write data.
- rd_data  out  WIDTH  combinational read of register at addr; unused bits 0.
- count  out  WIDTH  current counter value (registered).
- irq  out  1  STATUS & IE (registered state, no combinational path from inputs).

Behaviour:
- Reset values:
  - RELOAD = 0, COUNT = 0, CTRL = 0, PRESCALE = 0.
  - Internal prescale counter pcnt = 0, state = IDLE, irq = 0.
- CTRL bits:
  - [0] EN, [1] IE, [2] ONESHOT, [3] STATUS.
  - STATUS is write-1-to-clear; writing 0 leaves it unchanged.
  - Reads return all four bits.
- States:
  - IDLE (EN = 0): pcnt held at 0; COUNT held.
  - RUN (EN = 1).
  - IDLE -> RUN on a CTRL write with EN = 1.
  - RUN -> IDLE on a CTRL write with EN = 0, or on a one-shot overflow.
- Prescaler: in RUN with halt = 0, pcnt increments each cycle.
  - When pcnt == PRESCALE: tick asserts for one cycle and pcnt wraps to 0.
  - PRESCALE = 0 gives a tick every cycle.
- On tick:
  - If COUNT == all-ones: COUNT <= RELOAD and STATUS <= 1. If ONESHOT, EN <= 0 (state -> IDLE) in the same cycle.
  - Otherwise: COUNT <= COUNT + 1. Wrap is only via the reload path.
- Latency:
  - EN write at cycle n -> first increment at cycle n+1+PRESCALE.
  - STATUS and irq visible the cycle after the overflow tick.
- halt = 1: pcnt, COUNT and state frozen; no tick. Resuming continues from the frozen pcnt.
- Simultaneous events:
  - COUNT write and tick in the same cycle: the write wins and the tick is discarded.
  - PRESCALE write: pcnt <= 0.
  - Overflow setting STATUS and a W1C clearing it in the same cycle: set wins.
  - CTRL write with EN = 1 during a one-shot overflow: the write wins and the timer stays in RUN.
- RELOAD write takes effect at the next overflow.
- wr_data bits above a register's width are ignored.
- reset asserted mid-count: all state returns to reset values on that edge.

Optional Feature:
- Macro: SYSCLK_TIMER_CAPTURE_EN.
- When defined:
  - Adds input port cap_in (1 bit), and a CAPTURE register readable at addr 3, bits [WIDTH-1:PRESCALE_W].
  - A better choice is to widen addr to 3 bits and map CAPTURE at addr 4, which is what is decided.
  - cap_in is synchronised through 2 flops. On its synchronised rising edge, CAPTURE <= COUNT and CTRL[4] CAPF <= 1. CAPF is W1C.
  - Capture edge and tick in the same cycle: CAPTURE latches the pre-increment COUNT.
- When undefined: addr is 2 bits, there is no cap_in, CTRL[4] reads 0, and no capture logic is generated.

Decomposition:
- Shared package sysclk_timer_pkg:
  - Address constants ADDR_RELOAD/COUNT/CTRL/PRESCALE/CAPTURE.
  - CTRL bit index constants CTRL_EN/IE/ONESHOT/STATUS/CAPF.
  - State enum {IDLE, RUN}.
- One natural sub-module: sysclk_prescaler.
  - Contents: pcnt, tick generation, PRESCALE compare, halt gating, clear on PRESCALE write.
  - Instantiated once. Keep the counter/reload/status logic in the top.

Test Plan:
- Reset, then PRESCALE = 0, RELOAD = 0, CTRL = 0x1 -> count = 0,1,2,… on consecutive cycles; irq = 0.
- PRESCALE = 3, COUNT = 0, EN = 1 -> COUNT increments every 4th cycle; first increment 4 cycles after the EN write.
- RELOAD = 0xFFFFFFF0, COUNT = 0xFFFFFFFE, CTRL = 0x3 -> two ticks later COUNT = 0xFFFFFFF0, STATUS = 1, irq = 1. Writing CTRL = 0xB clears STATUS and drops irq the next cycle.
- ONESHOT: CTRL = 0x5, COUNT = 0xFFFFFFFF -> after one tick COUNT = RELOAD, EN reads 0, COUNT then stays constant for 20 cycles.
- halt = 1 for 10 cycles mid-run with PRESCALE = 2 -> COUNT and pcnt unchanged, then resume with the correct phase. A COUNT write during a tick cycle -> the written value is held with no +1.
- With SYSCLK_TIMER_CAPTURE_EN: pulse cap_in while COUNT = 0x100 -> CAPTURE = 0x100 (±sync latency of 2 cycles, checked exactly), CAPF = 1.

Source files
------------

// File: rtl/sysclk_timer_pkg.sv
// Shared constants and types for the sysclk_timer peripheral.
// Optional capture feature: define SYSCLK_TIMER_CAPTURE_EN (widens addr to 3 bits).
package sysclk_timer_pkg;

`ifdef SYSCLK_TIMER_CAPTURE_EN
   localparam int ADDR_W = 3;
`else
   localparam int ADDR_W = 2;
`endif

   localparam int ADDR_RELOAD   = 0;
   localparam int ADDR_COUNT    = 1;
   localparam int ADDR_CTRL     = 2;
   localparam int ADDR_PRESCALE = 3;
   localparam int ADDR_CAPTURE  = 4;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_IE      = 1;
   localparam int CTRL_ONESHOT = 2;
   localparam int CTRL_STATUS  = 3;
   localparam int CTRL_CAPF    = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/sysclk_prescaler.sv
// Prescale counter: emits a one-cycle tick every PRESCALE+1 running, non-halted cycles.
module sysclk_prescaler #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  run_i,
   input  logic                  halt_i,
   input  logic                  clr_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   output logic                  tick_o
);

   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

   assign tick_o = run_i && !halt_i && (pcnt_q == prescale_i);

   always_comb begin
      pcnt_d = pcnt_q;
      if (clr_i || !run_i) begin
         pcnt_d = '0;
      end else if (tick_o) begin
         pcnt_d = '0;
      end else if (!halt_i) begin
         pcnt_d = pcnt_q + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) pcnt_q <= '0;
      else       pcnt_q <= pcnt_d;
   end

endmodule

// File: rtl/sysclk_timer.sv
// Programmable up-counter timer with reload, prescaler, one-shot mode and maskable irq.
// Optional capture input and CAPTURE register when SYSCLK_TIMER_CAPTURE_EN is defined.
module sysclk_timer
   import sysclk_timer_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int PRESCALE_W = 8
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              halt,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wr_data,
   output logic [WIDTH-1:0]  rd_data,
   output logic [WIDTH-1:0]  count,
`ifdef SYSCLK_TIMER_CAPTURE_EN
   input  logic              cap_in,
`endif
   output logic              irq
);

   state_e                state_q, state_d;
   logic                  run;
   logic [WIDTH-1:0]      reload_q, reload_d;
   logic [WIDTH-1:0]      count_q, count_d;
   logic                  ie_q, ie_d, oneshot_q, oneshot_d, status_q, status_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic                  wr_reload, wr_count, wr_ctrl, wr_prescale;
   logic                  tick, ovf;

   assign wr_reload   = wr_en && (addr == ADDR_W'(ADDR_RELOAD));
   assign wr_count    = wr_en && (addr == ADDR_W'(ADDR_COUNT));
   assign wr_ctrl     = wr_en && (addr == ADDR_W'(ADDR_CTRL));
   assign wr_prescale = wr_en && (addr == ADDR_W'(ADDR_PRESCALE));

   sysclk_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk_i      (sysclk),
      .rst_i      (reset),
      .run_i      (run),
      .halt_i     (halt),
      .clr_i      (wr_prescale),
      .prescale_i (prescale_q),
      .tick_o     (tick)
   );

   // A COUNT write in the tick cycle swallows the tick, including any overflow.
   assign ovf = tick && !wr_count && (count_q == '1);

   always_ff @(posedge sysclk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (wr_ctrl)                state_d = wr_data[CTRL_EN] ? RUN : IDLE;
      else if (ovf && oneshot_q)  state_d = IDLE;
   end

   always_comb begin
      run = (state_q == RUN);
   end

   always_comb begin
      reload_d   = wr_reload ? wr_data : reload_q;
      prescale_d = wr_prescale ? wr_data[PRESCALE_W-1:0] : prescale_q;
      ie_d       = wr_ctrl ? wr_data[CTRL_IE] : ie_q;
      oneshot_d  = wr_ctrl ? wr_data[CTRL_ONESHOT] : oneshot_q;
      status_d   = status_q;
      if (ovf)                                status_d = 1'b1;
      else if (wr_ctrl && wr_data[CTRL_STATUS]) status_d = 1'b0;
      count_d = count_q;
      if (wr_count)  count_d = wr_data;
      else if (ovf)  count_d = reload_q;
      else if (tick) count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         reload_q   <= '0;
         count_q    <= '0;
         ie_q       <= 1'b0;
         oneshot_q  <= 1'b0;
         status_q   <= 1'b0;
         prescale_q <= '0;
      end else begin
         reload_q   <= reload_d;
         count_q    <= count_d;
         ie_q       <= ie_d;
         oneshot_q  <= oneshot_d;
         status_q   <= status_d;
         prescale_q <= prescale_d;
      end
   end

`ifdef SYSCLK_TIMER_CAPTURE_EN
   logic             cap_s1_q, cap_s2_q, cap_s3_q, cap_rise;
   logic [WIDTH-1:0] capture_q, capture_d;
   logic             capf_q, capf_d;

   assign cap_rise = cap_s2_q && !cap_s3_q;

   always_comb begin
      capture_d = cap_rise ? count_q : capture_q;
      capf_d    = capf_q;
      if (cap_rise)                         capf_d = 1'b1;
      else if (wr_ctrl && wr_data[CTRL_CAPF]) capf_d = 1'b0;
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         cap_s1_q  <= 1'b0;
         cap_s2_q  <= 1'b0;
         cap_s3_q  <= 1'b0;
         capture_q <= '0;
         capf_q    <= 1'b0;
      end else begin
         cap_s1_q  <= cap_in;
         cap_s2_q  <= cap_s1_q;
         cap_s3_q  <= cap_s2_q;
         capture_q <= capture_d;
         capf_q    <= capf_d;
      end
   end
`endif

   always_comb begin
      rd_data = '0;
      case (addr)
         ADDR_W'(ADDR_RELOAD):   rd_data = reload_q;
         ADDR_W'(ADDR_COUNT):    rd_data = count_q;
         ADDR_W'(ADDR_CTRL): begin
            rd_data[CTRL_EN]      = run;
            rd_data[CTRL_IE]      = ie_q;
            rd_data[CTRL_ONESHOT] = oneshot_q;
            rd_data[CTRL_STATUS]  = status_q;
`ifdef SYSCLK_TIMER_CAPTURE_EN
            rd_data[CTRL_CAPF]    = capf_q;
`endif
         end
         ADDR_W'(ADDR_PRESCALE): rd_data[PRESCALE_W-1:0] = prescale_q;
`ifdef SYSCLK_TIMER_CAPTURE_EN
         ADDR_W'(ADDR_CAPTURE):  rd_data = capture_q;
`endif
         default:                rd_data = '0;
      endcase
   end

   assign count = count_q;
   assign irq   = status_q & ie_q;

endmodule
